pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised MIPS inter-stage pipeline register. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers with one configurable block. The block carries a control bundle and a data bundle through a chain of `DEPTH` register slots, with a valid bit per slot and stall, flush and flush-all handling. Control bits are zeroed on every bubble, so downstream enables stay inert. Saturating stall and bubble counters support performance debug.

## Interface
- `DATA_W`, 32: width of the data bundle (PC, operands, immediate, destination register, packed by the instantiator).
- `CTRL_W`, 16: width of the control bundle (ALU op, RF/HI/LO/memory enables, size, sign, packed).
- `DEPTH`, 1: number of register slots in the chain, legal range 1..4.
- `Clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `In_Valid`, in, 1: the incoming entry is a real instruction.
- `In_Ctrl`, in, CTRL_W: incoming control bundle.
- `In_Data`, in, DATA_W: incoming data bundle.
- `Stall`, in, 1: hold every slot.
- `Flush`, in, 1: squash slot 0 (the newest entry).
- `Flush_All`, in, 1: squash every slot.
- `Count_Clear`, in, 1: synchronous clear of both counters.
- `Out_Valid`, out, 1: valid bit of slot DEPTH-1.
- `Out_Ctrl`, out, CTRL_W: control bundle of slot DEPTH-1.
- `Out_Data`, out, DATA_W: data bundle of slot DEPTH-1.
- `Slot_Valid`, out, DEPTH: per-slot valid bits, used by hazard detection. Bit i corresponds to slot i.
- `Stall_Count`, out, 16: saturating count of stalled cycles.
- `Bubble_Count`, out, 16: saturating count of bubbles inserted at slot 0.

## Operation
- Each slot holds `{valid, ctrl, data}`. Invariant: `valid=0` implies `ctrl=0`. Data is don't-care when invalid but is deterministic.
- Per rising edge, in priority order:
  1. `Flush_All=1`: every slot gets valid=0 and ctrl=0. Data is held. `Stall` and `Flush` are ignored.
  2. `Stall=1`: every slot holds. If `Flush=1` as well, slot 0 gets valid=0 and ctrl=0 with data held; the other slots hold.
  3. Otherwise the chain shifts:
     - Slot i takes slot i-1 for i=1..DEPTH-1.
     - Slot 0 takes `In_Data`.
     - Slot 0 valid becomes `In_Valid & ~Flush`.
     - Slot 0 ctrl becomes `In_Ctrl` when that valid is 1, otherwise 0.
- Bubble event: case 3 with `In_Valid=0` or `Flush=1`.
- Stall event: `Stall=1` and `Flush_All=0`.
- Counters:
  - `Count_Clear=1` sets both counters to 0 and takes priority over increment.
  - Otherwise each counter increments by 1 on its event.
  - Each counter saturates at 16'hFFFF and does not wrap.
- Outputs come directly from slot registers. There is no combinational path from any input to any output.
- With `DEPTH=1` and `Stall = ~LE`, behaviour equals the legacy single-register stage, with bubble zeroing added.

## Timing
- Latency: an entry presented at edge n appears on `Out_*` after edge n+DEPTH-1, i.e. DEPTH edges to output, provided no stall occurs. Each stalled cycle adds exactly one cycle.
- Reset (`Reset=0`, asynchronous):
  - All slot valid, ctrl and data are 0.
  - `Out_Valid=0`, `Out_Ctrl=0`, `Out_Data=0`, `Slot_Valid=0`.
  - Both counters are 0.
- Reset release is synchronous to `Clk`: the first capture occurs on the first rising edge where `Reset=1` was sampled.
- Reset asserted mid-stall or mid-flush clears state immediately, with no partial shift.
- `Flush` and `Flush_All` take effect at the same edge they are sampled. Squashed entries are invisible at the outputs on the following cycle.
- A held counter at 16'hFFFF stays at 16'hFFFF until `Count_Clear` or reset.

## Structure
- Package `mips_pipe_pkg` holds:
  - `PIPE_CNT_W = 16`;
  - the `DEPTH` legal range constants, with an elaboration-time check that 1 ≤ DEPTH ≤ 4;
  - the legacy control-bundle bit-position constants (ALU_OP, LOAD_INSTR, RF_ENABLE, HI_ENABLE, LO_ENABLE, PC_PLUS8_INSTR, OP_H_S, MEM_ENABLE, MEM_READWRITE, MEM_SIZE, MEM_SIGNE), so every stage packs `In_Ctrl` identically.
- Sub-module `pipe_stage_slot` implements one slot (valid/ctrl/data registers, hold, squash and load muxing). `pipe_stage_reg` generates DEPTH slots plus the two counters.

## Test plan
Bench parameters: DATA_W=32, CTRL_W=16, DEPTH=2.

1. Reset, then push A (In_Valid=1, ctrl=16'h00A5, data=32'h0040_0004) → `Out_Valid=1`, ctrl=16'h00A5 and data=32'h0040_0004 two edges later. `Slot_Valid` reads 2'b01, then 2'b11 if followed by another valid entry.
2. Push A, push B, then assert Stall for 3 cycles → outputs frozen on A. Slot_Valid=2'b11 throughout. Stall_Count=3. B reaches the output 1 edge after Stall drops.
3. Stall=1 and Flush=1 for one cycle with A in slot 1 and B in slot 0 → slot 0 becomes invalid with ctrl=0, so Slot_Valid=2'b10. A is unaffected. After release, the output shows A, then a bubble (Out_Valid=0, Out_Ctrl=0).
4. Flush_All with Stall=1 and two valid slots → next cycle Slot_Valid=2'b00, Out_Ctrl=0, Out_Data unchanged. Stall_Count does not increment.
5. In_Valid=0 for 70000 unstalled cycles → Bubble_Count=16'hFFFF and stays there. Count_Clear together with an event → 0 on the next cycle.
6. Assert Reset asynchronously, mid-cycle, while entries are in flight → all outputs and counters read 0 before the next clock edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared constants for the configurable MIPS inter-stage pipeline register:
// counter width, legal DEPTH range and the legacy control-bundle bit layout.
package mips_pipe_pkg;

    localparam int PIPE_CNT_W = 16;

    localparam int PIPE_DEPTH_MIN = 1;
    localparam int PIPE_DEPTH_MAX = 4;

    // Every stage packs In_Ctrl with these positions so bundles stay interchangeable
    localparam int CTRL_ALU_OP_LSB     = 0;
    localparam int CTRL_ALU_OP_W       = 4;
    localparam int CTRL_LOAD_INSTR     = 4;
    localparam int CTRL_RF_ENABLE      = 5;
    localparam int CTRL_HI_ENABLE      = 6;
    localparam int CTRL_LO_ENABLE      = 7;
    localparam int CTRL_PC_PLUS8_INSTR = 8;
    localparam int CTRL_OP_H_S         = 9;
    localparam int CTRL_MEM_ENABLE     = 10;
    localparam int CTRL_MEM_READWRITE  = 11;
    localparam int CTRL_MEM_SIZE_LSB   = 12;
    localparam int CTRL_MEM_SIZE_W     = 2;
    localparam int CTRL_MEM_SIGNE      = 14;

    function automatic bit pipeDepthOk(input int depth);
        return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping
    function automatic logic [PIPE_CNT_W-1:0] satInc(input logic [PIPE_CNT_W-1:0] cnt,
                                                     input logic                  ev);
        if (ev && (cnt != {PIPE_CNT_W{1'b1}})) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Entry bus into and out of a pipeline register stage. The producer side
// drives In_* and observes Out_*; the stage itself uses the slave view.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) ();

    logic              In_Valid;
    logic [CTRL_W-1:0] In_Ctrl;
    logic [DATA_W-1:0] In_Data;
    logic              Out_Valid;
    logic [CTRL_W-1:0] Out_Ctrl;
    logic [DATA_W-1:0] Out_Data;

    modport master (
        output In_Valid, In_Ctrl, In_Data,
        input  Out_Valid, Out_Ctrl, Out_Data
    );

    modport slave (
        input  In_Valid, In_Ctrl, In_Data,
        output Out_Valid, Out_Ctrl, Out_Data
    );

endinterface

// File: rtl/pipe_stage_slot.sv
// One register slot of the pipeline chain: squash beats hold beats load,
// and ctrl is forced to zero whenever the slot is not valid.
module pipe_stage_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_squash,
    input  logic              i_hold,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Squash keeps data so an invalid slot still reads deterministically
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_squash) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_ctrl  <= i_valid ? i_ctrl : '0;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable MIPS inter-stage register: DEPTH slots with stall/flush/flush-all
// handling plus saturating stall and bubble counters for performance debug.
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  Flush_All,
    input  logic                  Count_Clear,
    pipe_stage_reg_if.slave       bus,
    output logic [DEPTH-1:0]      Slot_Valid,
    output logic [PIPE_CNT_W-1:0] Stall_Count,
    output logic [PIPE_CNT_W-1:0] Bubble_Count
);

    if (!pipeDepthOk(DEPTH)) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be within 1..4");
    end

    logic [DEPTH-1:0]  w_valid;
    logic [CTRL_W-1:0] w_ctrl [DEPTH];
    logic [DATA_W-1:0] w_data [DEPTH];
    logic              w_stallEvent;
    logic              w_bubbleEvent;
    logic [PIPE_CNT_W-1:0] r_stallCount;
    logic [PIPE_CNT_W-1:0] r_bubbleCount;

    // Slot 0 is the only one that sees Flush and the incoming entry
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
                .Clk      (Clk),
                .Reset    (Reset),
                .i_squash (Flush_All | (Stall & Flush)),
                .i_hold   (Stall),
                .i_valid  (bus.In_Valid & ~Flush),
                .i_ctrl   (bus.In_Ctrl),
                .i_data   (bus.In_Data),
                .o_valid  (w_valid[i]),
                .o_ctrl   (w_ctrl[i]),
                .o_data   (w_data[i])
            );
        end else begin : g_tail
            pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
                .Clk      (Clk),
                .Reset    (Reset),
                .i_squash (Flush_All),
                .i_hold   (Stall),
                .i_valid  (w_valid[i-1]),
                .i_ctrl   (w_ctrl[i-1]),
                .i_data   (w_data[i-1]),
                .o_valid  (w_valid[i]),
                .o_ctrl   (w_ctrl[i]),
                .o_data   (w_data[i])
            );
        end
    end

    assign w_stallEvent  = Stall & ~Flush_All;
    assign w_bubbleEvent = ~Flush_All & ~Stall & (~bus.In_Valid | Flush);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_stallCount  <= '0;
            r_bubbleCount <= '0;
        end else if (Count_Clear) begin
            r_stallCount  <= '0;
            r_bubbleCount <= '0;
        end else begin
            r_stallCount  <= satInc(r_stallCount, w_stallEvent);
            r_bubbleCount <= satInc(r_bubbleCount, w_bubbleEvent);
        end
    end

    assign bus.Out_Valid = w_valid[DEPTH-1];
    assign bus.Out_Ctrl  = w_ctrl[DEPTH-1];
    assign bus.Out_Data  = w_data[DEPTH-1];
    assign Slot_Valid    = w_valid;
    assign Stall_Count   = r_stallCount;
    assign Bubble_Count  = r_bubbleCount;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg at DEPTH=2: directed scenarios followed by random
// traffic, all checked against a slot-array reference model.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int DEPTH  = 2;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        Flush_All;
    logic        Count_Clear;
    logic [1:0]  Slot_Valid;
    logic [15:0] Stall_Count;
    logic [15:0] Bubble_Count;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .Flush        (Flush),
        .Flush_All    (Flush_All),
        .Count_Clear  (Count_Clear),
        .bus          (bus.slave),
        .Slot_Valid   (Slot_Valid),
        .Stall_Count  (Stall_Count),
        .Bubble_Count (Bubble_Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        bit        v;
        bit [15:0] c;
        bit [31:0] d;
    } slot_t;

    slot_t m [DEPTH];
    int    mStall;
    int    mBubble;
    int    checks;
    int    errors;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m[i] = '{v: 1'b0, c: 16'h0, d: 32'h0};
        mStall  = 0;
        mBubble = 0;
    endtask

    // Applies one clock edge of the documented behaviour to the reference slots
    task automatic modelEdge();
        bit stallEv;
        bit bubbleEv;
        stallEv  = Stall && !Flush_All;
        bubbleEv = !Flush_All && !Stall && (!bus.In_Valid || Flush);
        if (Flush_All) begin
            for (int i = 0; i < DEPTH; i++) begin
                m[i].v = 1'b0;
                m[i].c = 16'h0;
            end
        end else if (Stall) begin
            if (Flush) begin
                m[0].v = 1'b0;
                m[0].c = 16'h0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) m[i] = m[i-1];
            m[0].d = bus.In_Data;
            m[0].v = bus.In_Valid && !Flush;
            m[0].c = m[0].v ? bus.In_Ctrl : 16'h0;
        end
        if (Count_Clear) begin
            mStall  = 0;
            mBubble = 0;
        end else begin
            if (stallEv  && mStall  < 65535) mStall++;
            if (bubbleEv && mBubble < 65535) mBubble++;
        end
    endtask

    task automatic checkModel();
        checkOutput("out_valid",  64'(bus.Out_Valid), 64'(m[DEPTH-1].v));
        checkOutput("out_ctrl",   64'(bus.Out_Ctrl),  64'(m[DEPTH-1].c));
        checkOutput("out_data",   64'(bus.Out_Data),  64'(m[DEPTH-1].d));
        checkOutput("slot_valid", 64'(Slot_Valid),    64'({m[1].v, m[0].v}));
        checkOutput("stall_cnt",  64'(Stall_Count),   64'(mStall));
        checkOutput("bubble_cnt", 64'(Bubble_Count),  64'(mBubble));
    endtask

    task automatic applyStimulus(input bit v, input bit [15:0] c, input bit [31:0] d,
                                 input bit st, input bit fl, input bit fa, input bit cc);
        bus.In_Valid = v;
        bus.In_Ctrl  = c;
        bus.In_Data  = d;
        Stall        = st;
        Flush        = fl;
        Flush_All    = fa;
        Count_Clear  = cc;
    endtask

    // One cycle: inputs already stable, edge, model update, sample 1 time unit later
    task automatic step(input bit doCheck);
        @(posedge Clk);
        modelEdge();
        #1;
        if (doCheck) checkModel();
    endtask

    task automatic doReset();
        Reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        modelReset();
        @(posedge Clk);
        #2;
        Reset = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        bus.In_Valid = 1'b0;
        bus.In_Ctrl  = '0;
        bus.In_Data  = '0;
        doReset();
        checkModel();
        checkOutput("reset_out_valid", 64'(bus.Out_Valid), 64'h0);
        checkOutput("reset_slot_valid", 64'(Slot_Valid), 64'h0);

        applyStimulus(1'b1, 16'h00A5, 32'h0040_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        checkOutput("t1_slot_valid_01", 64'(Slot_Valid), 64'h1);
        checkOutput("t1_out_valid_early", 64'(bus.Out_Valid), 64'h0);
        applyStimulus(1'b1, 16'h005A, 32'h0040_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        checkOutput("t1_out_valid", 64'(bus.Out_Valid), 64'h1);
        checkOutput("t1_out_ctrl", 64'(bus.Out_Ctrl), 64'h00A5);
        checkOutput("t1_out_data", 64'(bus.Out_Data), 64'h0040_0004);
        checkOutput("t1_slot_valid_11", 64'(Slot_Valid), 64'h3);

        applyStimulus(1'b1, 16'h1111, 32'h0040_000C, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            checkOutput("t2_frozen_ctrl", 64'(bus.Out_Ctrl), 64'h00A5);
            checkOutput("t2_slot_valid", 64'(Slot_Valid), 64'h3);
        end
        checkOutput("t2_stall_count", 64'(Stall_Count), 64'd3);
        applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        checkOutput("t2_b_out_ctrl", 64'(bus.Out_Ctrl), 64'h005A);
        checkOutput("t2_b_out_data", 64'(bus.Out_Data), 64'h0040_0008);

        applyStimulus(1'b1, 16'h00A5, 32'h0040_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        applyStimulus(1'b1, 16'h005A, 32'h0040_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        applyStimulus(1'b1, 16'h2222, 32'h0040_0010, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1);
        checkOutput("t3_slot_valid_10", 64'(Slot_Valid), 64'h2);
        checkOutput("t3_a_kept", 64'(bus.Out_Ctrl), 64'h00A5);
        applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        checkOutput("t3_bubble_valid", 64'(bus.Out_Valid), 64'h0);
        checkOutput("t3_bubble_ctrl", 64'(bus.Out_Ctrl), 64'h0);

        applyStimulus(1'b1, 16'h00A5, 32'h0040_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        applyStimulus(1'b1, 16'h005A, 32'h0040_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        applyStimulus(1'b1, 16'h3333, 32'h0040_0014, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1);
        checkOutput("t4_slot_valid_00", 64'(Slot_Valid), 64'h0);
        checkOutput("t4_out_ctrl", 64'(bus.Out_Ctrl), 64'h0);
        checkOutput("t4_out_data_held", 64'(bus.Out_Data), 64'h0040_0004);
        checkOutput("t4_stall_count", 64'(Stall_Count), 64'd4);

        applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1);
        applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 70000; k++) step((k % 5000) == 0);
        checkModel();
        checkOutput("t5_bubble_sat", 64'(Bubble_Count), 64'hFFFF);
        step(1'b1);
        checkOutput("t5_bubble_stays", 64'(Bubble_Count), 64'hFFFF);
        applyStimulus(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1);
        checkOutput("t5_clear_bubble", 64'(Bubble_Count), 64'h0);
        checkOutput("t5_clear_stall", 64'(Stall_Count), 64'h0);

        for (int k = 0; k < 2000; k++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom), 32'($urandom),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
            step(1'b1);
        end

        applyStimulus(1'b1, 16'h00A5, 32'h0040_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        applyStimulus(1'b1, 16'h005A, 32'h0040_0008, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        modelReset();
        #1;
        checkModel();
        checkOutput("t6_out_valid", 64'(bus.Out_Valid), 64'h0);
        checkOutput("t6_out_data", 64'(bus.Out_Data), 64'h0);
        checkOutput("t6_stall_cnt", 64'(Stall_Count), 64'h0);
        checkOutput("t6_bubble_cnt", 64'(Bubble_Count), 64'h0);
        applyStimulus(1'b1, 16'h0C0C, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        Reset = 1'b1;
        step(1'b1);
        step(1'b1);
        checkOutput("t6_post_reset_data", 64'(bus.Out_Data), 64'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
